// File: rtl/mul16s_arb_pkg.sv
// Shared types, constants and the round-robin pick helper for the multiplier arbiter.
package mul16s_arb_pkg;

    localparam int OP_W      = 16;
    localparam int RES_W     = 32;
    localparam int TRUNC     = 2;
    localparam int PROD_W    = 2 * (OP_W - TRUNC);
    localparam logic [3:0] LSB_PAD = 4'b0001;
    localparam int MAX_REQ   = 8;
    localparam int MAX_ID_W  = 3;
    localparam int MAX_TAG_W = 16;

    typedef struct packed {
        logic                 valid;
        logic [RES_W-1:0]     data;
        logic [MAX_ID_W-1:0]  id;
        logic [MAX_TAG_W-1:0] tag;
    } pipe_entry_t;

    // First valid requester at or after ptr, wrapping modulo n (n <= MAX_REQ, ptr < n).
    function automatic logic [MAX_ID_W-1:0] rr_pick(
        input logic [MAX_REQ-1:0]  valid,
        input logic [MAX_ID_W-1:0] ptr,
        input logic [MAX_ID_W:0]   n
    );
        logic [MAX_ID_W:0] idx;
        logic [MAX_ID_W:0] step;
        logic              found;
        rr_pick = '0;
        found   = 1'b0;
        for (int k = 0; k < MAX_REQ; k++) begin
            step = (MAX_ID_W + 1)'(k);
            idx  = {1'b0, ptr} + step;
            if (idx >= n) begin
                idx = idx - n;
            end
            if (!found && (step < n) && valid[idx[MAX_ID_W-1:0]]) begin
                rr_pick = idx[MAX_ID_W-1:0];
                found   = 1'b1;
            end
        end
    endfunction

endpackage

// File: rtl/mul16s_arb_pipe.sv
// LAT-deep stallable approximate multiplier pipe; the product is formed in stage 0.
module mul16s_arb_pipe
    import mul16s_arb_pkg::*;
#(
    parameter int LAT   = 2,
    parameter int ID_W  = 2,
    parameter int TAG_W = 4
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              stall,
    input  logic              in_valid,
    input  logic [OP_W-1:0]   in_a,
    input  logic [OP_W-1:0]   in_b,
    input  logic [ID_W-1:0]   in_id,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    output logic [RES_W-1:0]  out_data,
    output logic [ID_W-1:0]   out_id,
    output logic [TAG_W-1:0]  out_tag
);

    pipe_entry_t stage_q [LAT];
    pipe_entry_t stage_d [LAT];
    pipe_entry_t entry_in;

    logic signed [PROD_W-1:0] op_a;
    logic signed [PROD_W-1:0] op_b;
    logic signed [PROD_W-1:0] product;
    logic                     pipe_unused;

    // Bubbles carry an all-zero entry so the output bus is quiet when idle.
    always_comb begin
        op_a     = PROD_W'($signed(in_a[OP_W-1:TRUNC]));
        op_b     = PROD_W'($signed(in_b[OP_W-1:TRUNC]));
        product  = op_a * op_b;
        entry_in = '0;
        if (in_valid) begin
            entry_in.valid            = 1'b1;
            entry_in.data             = {product, LSB_PAD};
            entry_in.id[ID_W-1:0]     = in_id;
            entry_in.tag[TAG_W-1:0]   = in_tag;
        end
    end

    always_comb begin
        for (int i = 0; i < LAT; i++) begin
            stage_d[i] = stage_q[i];
        end
        if (!stall) begin
            stage_d[0] = entry_in;
            for (int i = 1; i < LAT; i++) begin
                stage_d[i] = stage_q[i-1];
            end
        end
    end

    always_ff @(posedge clock) begin
        for (int i = 0; i < LAT; i++) begin
            if (!reset_n) begin
                stage_q[i] <= '0;
            end else begin
                stage_q[i] <= stage_d[i];
            end
        end
    end

    assign out_valid   = stage_q[LAT-1].valid;
    assign out_data    = stage_q[LAT-1].data;
    assign out_id      = stage_q[LAT-1].id[ID_W-1:0];
    assign out_tag     = stage_q[LAT-1].tag[TAG_W-1:0];
    assign pipe_unused = ^{stage_q[LAT-1].id, stage_q[LAT-1].tag};

endmodule

// File: rtl/mul16s_arb_sched.sv
// Round-robin scheduler sharing one approximate 16x16 signed multiplier pipe among N_REQ requesters.
// Define MUL16S_ARB_STATS_EN to add per-requester grant and stall-cycle counters.
module mul16s_arb_sched
    import mul16s_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int LAT   = 2,
    parameter int TAG_W = 4
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic [N_REQ-1:0]           req_valid,
    output logic [N_REQ-1:0]           req_ready,
    input  logic [N_REQ*16-1:0]        req_a,
    input  logic [N_REQ*16-1:0]        req_b,
    input  logic [N_REQ*TAG_W-1:0]     req_tag,
    output logic                       resp_valid,
    input  logic                       resp_ready,
    output logic [31:0]                resp_data,
    output logic [$clog2(N_REQ)-1:0]   resp_id,
    output logic [TAG_W-1:0]           resp_tag
`ifdef MUL16S_ARB_STATS_EN
    ,
    output logic [N_REQ*16-1:0]        stat_grants,
    output logic [15:0]                stat_stalls
`else
`endif
);

    localparam int ID_W = $clog2(N_REQ);

    logic [ID_W-1:0]     ptr_q, ptr_d;
    logic [ID_W-1:0]     grant;
    logic [MAX_ID_W-1:0] pick;
    logic [MAX_ID_W-1:0] ptr_ext;
    logic [MAX_REQ-1:0]  valid_ext;
    logic                any_valid, stall, accept;
    logic [OP_W-1:0]     sel_a, sel_b;
    logic [TAG_W-1:0]    sel_tag;
    logic                sched_unused;

    always_comb begin
        valid_ext              = '0;
        valid_ext[N_REQ-1:0]   = req_valid;
        ptr_ext                = '0;
        ptr_ext[ID_W-1:0]      = ptr_q;
        pick                   = rr_pick(valid_ext, ptr_ext, (MAX_ID_W + 1)'(N_REQ));
        grant                  = pick[ID_W-1:0];
    end
    assign sched_unused = ^pick;

    // A held output freezes the pipe, so nothing may be accepted that cycle.
    assign any_valid = |req_valid;
    assign stall     = resp_valid & ~resp_ready;
    assign accept    = any_valid & ~stall;

    always_comb begin
        req_ready = '0;
        sel_a     = '0;
        sel_b     = '0;
        sel_tag   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant == ID_W'(i)) begin
                req_ready[i] = accept;
                sel_a        = req_a[i*OP_W +: OP_W];
                sel_b        = req_b[i*OP_W +: OP_W];
                sel_tag      = req_tag[i*TAG_W +: TAG_W];
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (accept) begin
            ptr_d = (grant == ID_W'(N_REQ - 1)) ? '0 : grant + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    mul16s_arb_pipe #(
        .LAT   (LAT),
        .ID_W  (ID_W),
        .TAG_W (TAG_W)
    ) u_pipe (
        .clock     (clock),
        .reset_n   (reset_n),
        .stall     (stall),
        .in_valid  (accept),
        .in_a      (sel_a),
        .in_b      (sel_b),
        .in_id     (grant),
        .in_tag    (sel_tag),
        .out_valid (resp_valid),
        .out_data  (resp_data),
        .out_id    (resp_id),
        .out_tag   (resp_tag)
    );

`ifdef MUL16S_ARB_STATS_EN
    logic [15:0] grant_cnt_q [N_REQ];
    logic [15:0] grant_cnt_d [N_REQ];
    logic [15:0] stall_cnt_q, stall_cnt_d;

    // Both counters saturate rather than wrap.
    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            grant_cnt_d[i] = grant_cnt_q[i];
            if (req_valid[i] && req_ready[i] && grant_cnt_q[i] != 16'hFFFF) begin
                grant_cnt_d[i] = grant_cnt_q[i] + 16'd1;
            end
            stat_grants[i*16 +: 16] = grant_cnt_q[i];
        end
        stall_cnt_d = stall_cnt_q;
        if (stall && stall_cnt_q != 16'hFFFF) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            for (int i = 0; i < N_REQ; i++) begin
                grant_cnt_q[i] <= '0;
            end
            stall_cnt_q <= '0;
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                grant_cnt_q[i] <= grant_cnt_d[i];
            end
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stat_stalls = stall_cnt_q;
`else
`endif

endmodule

// File: tb/tb_mul16s_arb_sched.sv
// Self-checking bench for mul16s_arb_sched: queue-based reference model plus directed literal checks.
// Stats checks are compiled in when MUL16S_ARB_STATS_EN is defined.
module tb_mul16s_arb_sched;

    localparam int N_REQ = 4;
    localparam int LAT   = 2;
    localparam int TAG_W = 4;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [63:0] req_a;
    logic [63:0] req_b;
    logic [15:0] req_tag;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_data;
    logic [1:0]  resp_id;
    logic [3:0]  resp_tag;
`ifdef MUL16S_ARB_STATS_EN
    logic [63:0] stat_grants;
    logic [15:0] stat_stalls;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clock = ~clock;

    mul16s_arb_sched #(.N_REQ(N_REQ), .LAT(LAT), .TAG_W(TAG_W)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_tag    (req_tag),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_id    (resp_id),
        .resp_tag   (resp_tag)
`ifdef MUL16S_ARB_STATS_EN
        ,
        .stat_grants(stat_grants),
        .stat_stalls(stat_stalls)
`endif
    );

    // Reference model: in-flight results with the number of pipe advances since accept.
    typedef struct {
        int          age;
        logic [31:0] data;
        int          id;
        logic [3:0]  tag;
    } item_t;

    item_t mq[$];
    int    m_ptr = 0;

    function automatic logic [31:0] model_mul(input logic [15:0] a, input logic [15:0] b);
        int ai;
        int bi;
        ai = $signed(a);
        bi = $signed(b);
        ai = ai >>> 2;
        bi = bi >>> 2;
        return 32'(ai * bi * 16 + 1);
    endfunction

    function automatic int model_rr(input logic [3:0] v, input int p);
        for (int k = 0; k < N_REQ; k++) begin
            if (v[(p + k) % N_REQ]) return (p + k) % N_REQ;
        end
        return -1;
    endfunction

    function automatic logic model_has_out();
        return (mq.size() > 0) && (mq[0].age == LAT);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] valid, input logic rdy);
        @(posedge clock);
        #1;
        req_valid  = valid;
        resp_ready = rdy;
    endtask

    always @(posedge clock) begin
        int    g;
        logic  stall;
        item_t it;
        if (!reset_n) begin
            mq.delete();
            m_ptr = 0;
        end else begin
            stall = model_has_out() && !resp_ready;
            if (!stall) begin
                foreach (mq[i]) mq[i].age++;
                while (mq.size() > 0 && mq[0].age > LAT) void'(mq.pop_front());
                if (req_valid != 4'b0) begin
                    g       = model_rr(req_valid, m_ptr);
                    it.age  = 1;
                    it.data = model_mul(req_a[g*16 +: 16], req_b[g*16 +: 16]);
                    it.id   = g;
                    it.tag  = req_tag[g*4 +: 4];
                    mq.push_back(it);
                    m_ptr = (g + 1) % N_REQ;
                end
            end
        end
    end

    always @(negedge clock) begin
        logic       exp_valid;
        logic       exp_stall;
        logic [3:0] exp_ready;
        if (reset_n === 1'b1) begin
            exp_valid = model_has_out();
            exp_stall = exp_valid && !resp_ready;
            exp_ready = 4'b0;
            if (req_valid != 4'b0 && !exp_stall) exp_ready[model_rr(req_valid, m_ptr)] = 1'b1;
            checkOutput("req_ready", 32'(req_ready), 32'(exp_ready));
            checkOutput("resp_valid", 32'(resp_valid), 32'(exp_valid));
            if (exp_valid) begin
                checkOutput("resp_data", resp_data, mq[0].data);
                checkOutput("resp_id", 32'(resp_id), 32'(mq[0].id));
                checkOutput("resp_tag", 32'(resp_tag), 32'(mq[0].tag));
            end
        end
    end

    task automatic sendOne(input int idx, input logic [15:0] a, input logic [15:0] b,
                           input logic [3:0] tag, input logic [31:0] exp_d, input string name);
        int lat;
        @(posedge clock);
        #1;
        req_a[idx*16 +: 16] = a;
        req_b[idx*16 +: 16] = b;
        req_tag[idx*4 +: 4] = tag;
        req_valid           = 4'(1 << idx);
        resp_ready          = 1'b1;
        @(negedge clock);
        checkOutput({name, "_ready"}, 32'(req_ready), 32'(1 << idx));
        @(posedge clock);
        #1;
        req_valid = 4'b0;
        lat = 0;
        do begin
            @(negedge clock);
            lat++;
        end while (resp_valid !== 1'b1 && lat < 20);
        checkOutput({name, "_latency"}, 32'(lat), 32'(LAT));
        checkOutput({name, "_data"}, resp_data, exp_d);
        checkOutput({name, "_id"}, 32'(resp_id), 32'(idx));
        checkOutput({name, "_tag"}, 32'(resp_tag), 32'(tag));
    endtask

    initial begin
        logic [31:0] hold_data;
        logic [1:0]  hold_id;

        reset_n    = 1'b0;
        req_valid  = 4'b0;
        req_a      = '0;
        req_b      = '0;
        req_tag    = '0;
        resp_ready = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b1;

        @(negedge clock);
        checkOutput("reset_resp_valid", 32'(resp_valid), 32'd0);
        checkOutput("reset_resp_data", resp_data, 32'd0);
        checkOutput("reset_resp_id", 32'(resp_id), 32'd0);
        checkOutput("reset_resp_tag", 32'(resp_tag), 32'd0);
        checkOutput("reset_req_ready", 32'(req_ready), 32'd0);

        sendOne(0, 16'd4, 16'd4, 4'd3, 32'h0000_0011, "pos");
        sendOne(1, 16'hFFFC, 16'd4, 4'd5, 32'hFFFF_FFF1, "neg");
        sendOne(2, 16'd0, 16'd1234, 4'd9, 32'h0000_0001, "zero");
        sendOne(3, 16'd3, 16'd3, 4'd15, 32'h0000_0001, "trunc");

        // All requesters busy: strict rotation from ptr 0, one result per cycle.
        @(posedge clock);
        #1;
        for (int i = 0; i < N_REQ; i++) begin
            req_a[i*16 +: 16] = 16'(8 * (i + 1));
            req_b[i*16 +: 16] = 16'(-12 * (i + 2));
            req_tag[i*4 +: 4] = 4'(i + 6);
        end
        req_valid = 4'hF;
        for (int k = 0; k < 12; k++) begin
            @(negedge clock);
            checkOutput("rr_grant", 32'(req_ready), 32'(1 << (k % 4)));
            if (k >= LAT) begin
                checkOutput("rr_resp_valid", 32'(resp_valid), 32'd1);
                checkOutput("rr_resp_id", 32'(resp_id), 32'((k - LAT) % 4));
            end
            @(posedge clock);
        end

        #1;
        resp_ready = 1'b0;
        hold_data  = 32'd0;
        hold_id    = 2'd0;
        for (int s = 0; s < 5; s++) begin
            @(negedge clock);
            checkOutput("stall_req_ready", 32'(req_ready), 32'd0);
            checkOutput("stall_resp_valid", 32'(resp_valid), 32'd1);
            if (s == 0) begin
                hold_data = resp_data;
                hold_id   = resp_id;
            end else begin
                checkOutput("stall_hold_data", resp_data, hold_data);
                checkOutput("stall_hold_id", 32'(resp_id), 32'(hold_id));
            end
        end
        applyStimulus(4'b0, 1'b1);
        repeat (LAT + 2) @(posedge clock);

        // Two entries in flight and ptr moved off zero, then a one-cycle reset.
        applyStimulus(4'b0010, 1'b1);
        @(posedge clock);
        @(posedge clock);
        #1;
        req_valid = 4'b0;
        reset_n   = 1'b0;
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            checkOutput("post_reset_resp_valid", 32'(resp_valid), 32'd0);
        end
        applyStimulus(4'hF, 1'b1);
        @(negedge clock);
        checkOutput("post_reset_ptr", 32'(req_ready), 32'b0001);
        applyStimulus(4'b1000, 1'b1);
        @(negedge clock);
        checkOutput("post_reset_req3", 32'(req_ready), 32'b1000);
        applyStimulus(4'b0, 1'b1);
        repeat (LAT + 2) @(posedge clock);

        for (int c = 0; c < 400; c++) begin
            @(posedge clock);
            #1;
            req_valid  = 4'($urandom);
            req_a      = {$urandom, $urandom};
            req_b      = {$urandom, $urandom};
            req_tag    = 16'($urandom);
            resp_ready = ($urandom_range(0, 3) != 0);
        end
        applyStimulus(4'b0, 1'b1);
        repeat (LAT + 3) @(posedge clock);

`ifdef MUL16S_ARB_STATS_EN
        #1;
        reset_n = 1'b0;
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        @(negedge clock);
        checkOutput("stat_grants_reset", stat_grants[31:0], 32'd0);
        checkOutput("stat_stalls_reset", 32'(stat_stalls), 32'd0);
        applyStimulus(4'b0100, 1'b1);
        repeat (9) @(posedge clock);
        @(posedge clock);
        #1;
        req_valid  = 4'b0;
        resp_ready = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        resp_ready = 1'b1;
        repeat (LAT + 2) @(posedge clock);
        @(negedge clock);
        checkOutput("stat_grants2", 32'(stat_grants[47:32]), 32'd10);
        checkOutput("stat_grants0", 32'(stat_grants[15:0]), 32'd0);
        checkOutput("stat_stalls", 32'(stat_stalls), 32'd3);
`endif

        @(negedge clock);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
